// File: rtl/noc_pkg.sv
// Shared encodings for the NoC flit traffic generator: modes, flit field
// offsets, FSM states and the 16-bit Galois LFSR step function.
package noc_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_RAND  = 2'd2;

    // Flit layout from the LSB: valid, to, id, then seq at the MSBs
    localparam int unsigned FLIT_VALID_BIT = 0;
    localparam int unsigned FLIT_TO_LSB    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle with step high.
// A non-zero SEED keeps the register out of the all-zero lock-up state.
module lfsr16
    import noc_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] q
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = lfsr16_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/noc_traffic_gen.sv
// Flit source for one router input FIFO: fixed / round-robin / LFSR-random
// destinations, inter-flit gaps, flit budget and full/almost_full back-pressure.
module noc_traffic_gen
    import noc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned SEQ_W     = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter bit          SKIP_SELF = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [ID_W-1:0]  id,
    input  logic [ID_W-1:0]  fixed_to,
    input  logic [3:0]       gap,
    input  logic [15:0]      max_count,
    input  logic             full,
    input  logic             almost_full,
    output logic [WIDTH-1:0] dataOut,
    output logic             write,
    output logic [15:0]      sent_count,
    output logic             done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned ID_LSB = FLIT_TO_LSB + ID_W;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               write_q, write_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               done_q, done_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ID_W-1:0]    rr_q, rr_d;

    logic [LFSR_W-1:0]  lfsr_q;
    logic               lfsr_step_c;
    logic               lfsr_unused_c;

    logic [ID_W-1:0]    cand_c;
    logic [ID_W-1:0]    to_sel_c;
    logic               hunt_c;
    logic               stall_c;
    logic               issue_c;
    logic               budget_met_c;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step_c),
        .q     (lfsr_q)
    );

    assign lfsr_unused_c = ^lfsr_q[LFSR_W-1:ID_W];

    // Destination candidate, bumped past our own id in RR/random when asked
    always_comb begin
        case (mode)
            MODE_RR:   cand_c = rr_q;
            MODE_RAND: cand_c = lfsr_q[ID_W-1:0];
            default:   cand_c = fixed_to;
        endcase
        hunt_c   = (mode == MODE_RR) || (mode == MODE_RAND);
        to_sel_c = cand_c;
        if (SKIP_SELF && hunt_c && (cand_c == id)) begin
            to_sel_c = cand_c + ID_W'(1);
        end
    end

    // A write already in flight counts against almost_full; otherwise only full blocks
    assign stall_c      = (write_q & almost_full) | (~write_q & full);
    assign issue_c      = (state_q == ST_SEND) & enable & ~stall_c;
    assign budget_met_c = (max_count != '0) &&
                          (({1'b0, sent_q} + 17'd1) == {1'b0, max_count});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (issue_c) begin
                    if (budget_met_c) begin
                        state_d = ST_DONE;
                    end else if (gap != '0) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        write_d     = 1'b0;
        seq_d       = seq_q;
        sent_d      = sent_q;
        done_d      = done_q;
        gap_d       = gap_q;
        rr_d        = rr_q;
        lfsr_step_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    rr_d = fixed_to;
                end
            end
            ST_SEND: begin
                if (issue_c) begin
                    write_d                        = 1'b1;
                    data_d[FLIT_VALID_BIT]         = 1'b1;
                    data_d[FLIT_TO_LSB +: ID_W]    = to_sel_c;
                    data_d[ID_LSB +: ID_W]         = id;
                    data_d[WIDTH-1 -: SEQ_W]       = seq_q;
                    seq_d                          = seq_q + SEQ_W'(1);
                    sent_d = (sent_q == {CNT_W{1'b1}}) ? sent_q : sent_q + CNT_W'(1);
                    gap_d  = gap;
                    // RR resumes after the destination actually used, so a skip is not repeated
                    if (mode == MODE_RR) begin
                        rr_d = to_sel_c + ID_W'(1);
                    end
                    if (mode == MODE_RAND) begin
                        lfsr_step_c = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_W'(1);
            end
            ST_DONE: begin
                if (enable) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                    sent_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            write_q <= 1'b0;
            seq_q   <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
            gap_q   <= '0;
            rr_q    <= '0;
        end else begin
            data_q  <= data_d;
            write_q <= write_d;
            seq_q   <= seq_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
        end
    end

    assign dataOut    = data_q;
    assign write      = write_q;
    assign sent_count = sent_q;
    assign done       = done_q;

endmodule
